// File: rtl/ap_ctrl_perf_pkg.sv
// Shared types and helpers for the ap_ctrl_chain performance monitor:
// FSM states, read-port field codes, saturating increment and the per-channel stats bundle.
package ap_ctrl_perf_pkg;

    // Widest supported counter; stats are carried at this width and trimmed at the read port.
    localparam int MAX_W = 48;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [2:0] SEL_TXN     = 3'd0;
    localparam logic [2:0] SEL_LAST    = 3'd1;
    localparam logic [2:0] SEL_MIN     = 3'd2;
    localparam logic [2:0] SEL_MAX     = 3'd3;
    localparam logic [2:0] SEL_STALL   = 3'd4;
    localparam logic [2:0] SEL_OVERLAP = 3'd5;
    localparam logic [2:0] SEL_II      = 3'd6;
    localparam logic [2:0] SEL_STATE   = 3'd7;

    typedef struct packed {
        logic [MAX_W-1:0] txn;
        logic [MAX_W-1:0] last_lat;
        logic [MAX_W-1:0] min_lat;
        logic [MAX_W-1:0] max_lat;
        logic [MAX_W-1:0] stall;
        logic [MAX_W-1:0] overlap;
        logic [MAX_W-1:0] ii;
        state_e           state;
    } stats_t;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] value, input int width);
        logic [MAX_W-1:0] limit;
        limit = {MAX_W{1'b1}} >> (MAX_W - width);
        if (value >= limit) begin
            sat_inc = limit;
        end else begin
            sat_inc = value + 48'd1;
        end
    endfunction

endpackage

// File: rtl/ap_ctrl_perf_chan.sv
// One monitored ap_ctrl_chain handshake: IDLE/RUN/HOLD FSM plus saturating statistics.
// Initiation-interval capture is compiled in only when AP_CTRL_PERF_II_EN is defined.
module ap_ctrl_perf_chan
    import ap_ctrl_perf_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   ap_start,
    input  logic   ap_ready,
    input  logic   ap_done,
    input  logic   ap_continue,
    input  logic   freeze,
    input  logic   clear,
    output stats_t stats,
    output logic   busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ALL1 = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] value);
        return CNT_W'(sat_inc(MAX_W'(value), CNT_W));
    endfunction

    state_e           state_r, state_nx_s;
    logic [CNT_W-1:0] lat_r, lat_nx_s, rec_lat_s;
    logic [CNT_W-1:0] txn_r, last_r, min_r, max_r, stall_r, ovl_r;
    logic             busy_r, rec_s, stall_inc_s, ovl_inc_s, acc_start_s;

    // Next-state, latency and event decode for the handshake FSM.
    always_comb begin
        state_nx_s  = state_r;
        lat_nx_s    = lat_r;
        rec_lat_s   = lat_r;
        rec_s       = 1'b0;
        stall_inc_s = 1'b0;
        ovl_inc_s   = 1'b0;
        acc_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ap_start) begin
                    acc_start_s = 1'b1;
                    lat_nx_s    = CNT_ONE;
                    // A block that completes in its start cycle still counts as a 1-cycle transaction.
                    if (ap_done && ap_continue) begin
                        rec_s      = 1'b1;
                        rec_lat_s  = CNT_ONE;
                        state_nx_s = ST_IDLE;
                    end else if (ap_done) begin
                        stall_inc_s = 1'b1;
                        state_nx_s  = ST_HOLD;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                lat_nx_s = inc(lat_r);
                if (ap_done && ap_continue) begin
                    rec_s     = 1'b1;
                    rec_lat_s = inc(lat_r);
                    if (ap_start) begin
                        acc_start_s = 1'b1;
                        lat_nx_s    = CNT_ONE;
                        state_nx_s  = ST_RUN;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else if (ap_done) begin
                    stall_inc_s = 1'b1;
                    state_nx_s  = ST_HOLD;
                end else begin
                    ovl_inc_s  = ap_ready;
                    state_nx_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (ap_continue) begin
                    rec_s = 1'b1;
                    if (ap_start) begin
                        acc_start_s = 1'b1;
                        lat_nx_s    = CNT_ONE;
                        state_nx_s  = ST_RUN;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    stall_inc_s = 1'b1;
                    state_nx_s  = ST_HOLD;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                lat_nx_s   = CNT_ZERO;
            end
        endcase
    end

    // State and statistics registers; clear wins over freeze, freeze drops events.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            lat_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            txn_r   <= CNT_ZERO;
            last_r  <= CNT_ZERO;
            min_r   <= CNT_ALL1;
            max_r   <= CNT_ZERO;
            stall_r <= CNT_ZERO;
            ovl_r   <= CNT_ZERO;
        end else if (clear) begin
            state_r <= ST_IDLE;
            lat_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            txn_r   <= CNT_ZERO;
            last_r  <= CNT_ZERO;
            min_r   <= CNT_ALL1;
            max_r   <= CNT_ZERO;
            stall_r <= CNT_ZERO;
            ovl_r   <= CNT_ZERO;
        end else if (!freeze) begin
            state_r <= state_nx_s;
            lat_r   <= lat_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            if (rec_s) begin
                txn_r  <= inc(txn_r);
                last_r <= rec_lat_s;
                if (rec_lat_s < min_r) min_r <= rec_lat_s;
                if (rec_lat_s > max_r) max_r <= rec_lat_s;
            end
            if (stall_inc_s) stall_r <= inc(stall_r);
            if (ovl_inc_s)   ovl_r   <= inc(ovl_r);
        end
    end

`ifdef AP_CTRL_PERF_II_EN
    logic [CNT_W-1:0] ii_cnt_r, ii_last_r;
    logic             ii_seen_r;

    // Cycles between accepted starts; the first start only arms the measurement.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ii_cnt_r  <= CNT_ZERO;
            ii_last_r <= CNT_ZERO;
            ii_seen_r <= 1'b0;
        end else if (clear) begin
            ii_cnt_r  <= CNT_ZERO;
            ii_last_r <= CNT_ZERO;
            ii_seen_r <= 1'b0;
        end else if (!freeze) begin
            if (acc_start_s) begin
                ii_cnt_r  <= CNT_ONE;
                ii_seen_r <= 1'b1;
                if (ii_seen_r) ii_last_r <= ii_cnt_r;
            end else begin
                ii_cnt_r <= inc(ii_cnt_r);
            end
        end
    end

    assign stats.ii = MAX_W'(ii_last_r);
`else
    logic unused_acc_start_s;
    assign unused_acc_start_s = acc_start_s;
    assign stats.ii           = {MAX_W{1'b0}};
`endif

    assign stats.txn      = MAX_W'(txn_r);
    assign stats.last_lat = MAX_W'(last_r);
    assign stats.min_lat  = MAX_W'(min_r);
    assign stats.max_lat  = MAX_W'(max_r);
    assign stats.stall    = MAX_W'(stall_r);
    assign stats.overlap  = MAX_W'(ovl_r);
    assign stats.state    = state_r;
    assign busy           = busy_r;

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Hardware performance monitor for NUM_CH ap_ctrl_chain handshakes with a registered read port.
// Define AP_CTRL_PERF_II_EN to add per-channel initiation-interval capture on rd_sel 6.
module ap_ctrl_perf_monitor
    import ap_ctrl_perf_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              freeze,
    input  logic              clear,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] busy
);

    // Every encodable rd_ch gets a slot; slots past NUM_CH read as zero.
    localparam int NUM_SLOT = 2 ** CH_W;

    stats_t           slot_s [NUM_SLOT];
    logic [MAX_W-1:0] field_s;
    logic [CNT_W-1:0] rd_data_r;

    for (genvar i = 0; i < NUM_SLOT; i++) begin : g_slot
        if (i < NUM_CH) begin : g_chan
            ap_ctrl_perf_chan #(.CNT_W(CNT_W)) u_chan (
                .clock       (clock),
                .reset       (reset),
                .ap_start    (ap_start[i]),
                .ap_ready    (ap_ready[i]),
                .ap_done     (ap_done[i]),
                .ap_continue (ap_continue[i]),
                .freeze      (freeze),
                .clear       (clear),
                .stats       (slot_s[i]),
                .busy        (busy[i])
            );
        end else begin : g_empty
            assign slot_s[i] = {$bits(stats_t){1'b0}};
        end
    end

    // Field select for the addressed channel.
    always_comb begin
        field_s = {MAX_W{1'b0}};
        case (rd_sel)
            SEL_TXN:     field_s = slot_s[rd_ch].txn;
            SEL_LAST:    field_s = slot_s[rd_ch].last_lat;
            SEL_MIN:     field_s = slot_s[rd_ch].min_lat;
            SEL_MAX:     field_s = slot_s[rd_ch].max_lat;
            SEL_STALL:   field_s = slot_s[rd_ch].stall;
            SEL_OVERLAP: field_s = slot_s[rd_ch].overlap;
            SEL_II:      field_s = slot_s[rd_ch].ii;
            SEL_STATE:   field_s = MAX_W'(slot_s[rd_ch].state);
            default:     field_s = {MAX_W{1'b0}};
        endcase
    end

    if (CNT_W < MAX_W) begin : g_unused_hi
        logic unused_hi_s;
        assign unused_hi_s = ^field_s[MAX_W-1:CNT_W];
    end

    // Read data register; stays live under freeze.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            rd_data_r <= {CNT_W{1'b0}};
        end else begin
            rd_data_r <= field_s[CNT_W-1:0];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Directed self-checking bench for ap_ctrl_perf_monitor (5 channels, 8-bit counters).
module tb_ap_ctrl_perf_monitor;

    localparam int NCH = 5;
    localparam int CW  = 8;
    localparam int CHW = 3;

    logic           clock = 1'b0;
    logic           reset;
    logic [NCH-1:0] ap_start, ap_ready, ap_done, ap_continue, busy;
    logic           freeze, clear;
    logic [CHW-1:0] rd_ch;
    logic [2:0]     rd_sel;
    logic [CW-1:0]  rd_data;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    ap_ctrl_perf_monitor #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_continue (ap_continue),
        .freeze      (freeze),
        .clear       (clear),
        .rd_ch       (rd_ch),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input int ch, input int sel, output logic [CW-1:0] v);
        rd_ch  = CHW'(ch);
        rd_sel = 3'(sel);
        tick();
        v = rd_data;
    endtask

    task automatic test_reset();
        logic [CW-1:0] v;
        logic [CW-1:0] exp [8];
        exp = '{8'd0, 8'd0, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        repeat (3) tick();
        vectors++;
        if (busy !== 5'd0 || rd_data !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b rd_data=%h expected 0/0", busy, rd_data);
        end
        reset = 1'b1;
        for (int s = 0; s < 8; s++) begin
            rd(0, s, v);
            vectors++;
            if (v !== exp[s]) begin
                miscompares++;
                $display("FAIL reset_sel%0d: got %h expected %h", s, v, exp[s]);
            end
        end
    endtask

    task automatic test_single();
        logic [CW-1:0] v;
        logic [CW-1:0] exp [8];
        exp = '{8'd1, 8'd5, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0};
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
        vectors++;
        if (busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy_run: got %b expected 1", busy[0]);
        end
        repeat (3) tick();
        ap_done[0] = 1'b1;
        tick();
        ap_done[0] = 1'b0;
        vectors++;
        if (busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_busy_idle: got %b expected 0", busy[0]);
        end
        for (int s = 0; s < 8; s++) begin
            if (s != 6) begin
                rd(0, s, v);
                vectors++;
                if (v !== exp[s]) begin
                    miscompares++;
                    $display("FAIL single_sel%0d: got %0d expected %0d", s, v, exp[s]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] v;
        logic [CW-1:0] exp [6];
        exp = '{8'd3, 8'd4, 8'd3, 8'd7, 8'd0, 8'd0};
        for (int k = 0; k < 12; k++) begin
            ap_start[1] = (k == 0 || k == 2 || k == 8);
            ap_ready[1] = (k == 0 || k == 2 || k == 8);
            ap_done[1]  = (k == 2 || k == 8 || k == 11);
            tick();
            if (k < 11) begin
                vectors++;
                if (busy[1] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_busy cycle %0d: got %b expected 1", k, busy[1]);
                end
            end
        end
        ap_start[1] = 1'b0; ap_ready[1] = 1'b0; ap_done[1] = 1'b0;
        for (int s = 0; s < 6; s++) begin
            rd(1, s, v);
            vectors++;
            if (v !== exp[s]) begin
                miscompares++;
                $display("FAIL b2b_sel%0d: got %0d expected %0d", s, v, exp[s]);
            end
        end
    endtask

    task automatic test_stall();
        logic [CW-1:0] v;
        rd_ch = 3'd2;
        for (int k = 0; k < 12; k++) begin
            ap_start[2]    = (k == 0);
            ap_ready[2]    = (k == 0);
            ap_done[2]     = (k == 4);
            ap_continue[2] = !(k >= 4 && k <= 9);
            rd_sel         = (k < 8) ? 3'd7 : 3'd0;
            tick();
            if (k == 7) begin
                vectors++;
                if (rd_data !== 8'd2) begin
                    miscompares++;
                    $display("FAIL stall_hold_state: got %0d expected 2", rd_data);
                end
            end
            if (k == 10) begin
                vectors++;
                if (rd_data !== 8'd0) begin
                    miscompares++;
                    $display("FAIL stall_txn_before_continue: got %0d expected 0", rd_data);
                end
            end
            if (k == 11) begin
                vectors++;
                if (rd_data !== 8'd1) begin
                    miscompares++;
                    $display("FAIL stall_txn_after_continue: got %0d expected 1", rd_data);
                end
            end
        end
        ap_start[2] = 1'b0; ap_ready[2] = 1'b0; ap_done[2] = 1'b0; ap_continue[2] = 1'b1;
        rd(2, 4, v);
        vectors++;
        if (v !== 8'd6) begin
            miscompares++;
            $display("FAIL stall_cnt: got %0d expected 6", v);
        end
        rd(2, 1, v);
        vectors++;
        if (v !== 8'd5) begin
            miscompares++;
            $display("FAIL stall_last_lat: got %0d expected 5", v);
        end
    endtask

    task automatic test_overlap_sat();
        logic [CW-1:0] v;
        logic [CW-1:0] exp [4];
        for (int k = 0; k < 300; k++) begin
            ap_start[3] = (k == 0);
            ap_ready[3] = (k == 0 || k == 3 || k == 6);
            ap_done[3]  = (k == 299);
            tick();
        end
        exp = '{8'd1, 8'd255, 8'd255, 8'd2};
        for (int i = 0; i < 4; i++) begin
            rd(3, (i == 3) ? 5 : i * 2 - ((i == 0) ? 0 : 1), v);
            vectors++;
            if (v !== exp[i]) begin
                miscompares++;
                $display("FAIL ovl_long item%0d: got %0d expected %0d", i, v, exp[i]);
            end
        end
        ap_start[3] = 1'b1; ap_ready[3] = 1'b1; ap_done[3] = 1'b1;
        repeat (300) tick();
        ap_start[3] = 1'b0; ap_ready[3] = 1'b0; ap_done[3] = 1'b0;
        rd(3, 0, v);
        vectors++;
        if (v !== 8'd255) begin
            miscompares++;
            $display("FAIL sat_txn: got %0d expected 255", v);
        end
        rd(3, 2, v);
        vectors++;
        if (v !== 8'd1) begin
            miscompares++;
            $display("FAIL sat_min: got %0d expected 1", v);
        end
        rd(3, 5, v);
        vectors++;
        if (v !== 8'd2) begin
            miscompares++;
            $display("FAIL sat_overlap: got %0d expected 2", v);
        end
    endtask

    task automatic test_same_cycle();
        logic [CW-1:0] v;
        ap_start[4] = 1'b1; ap_ready[4] = 1'b1; ap_done[4] = 1'b1;
        tick();
        ap_start[4] = 1'b0; ap_ready[4] = 1'b0; ap_done[4] = 1'b0;
        vectors++;
        if (busy[4] !== 1'b0) begin
            miscompares++;
            $display("FAIL same_cycle_busy: got %b expected 0", busy[4]);
        end
        rd(4, 1, v);
        vectors++;
        if (v !== 8'd1) begin
            miscompares++;
            $display("FAIL same_cycle_lat: got %0d expected 1", v);
        end
    endtask

    task automatic test_ii();
        logic [CW-1:0] v;
        for (int k = 0; k < 16; k++) begin
            ap_start[2] = (k == 0 || k == 7 || k == 11);
            ap_ready[2] = (k == 0 || k == 7 || k == 11);
            ap_done[2]  = (k == 7 || k == 11 || k == 15);
            tick();
        end
        ap_start[2] = 1'b0; ap_ready[2] = 1'b0; ap_done[2] = 1'b0;
        rd(2, 0, v);
        vectors++;
        if (v !== 8'd4) begin
            miscompares++;
            $display("FAIL ii_txn: got %0d expected 4", v);
        end
        rd(2, 6, v);
        vectors++;
`ifdef AP_CTRL_PERF_II_EN
        if (v !== 8'd4) begin
            miscompares++;
            $display("FAIL ii_last: got %0d expected 4", v);
        end
`else
        if (v !== 8'd0) begin
            miscompares++;
            $display("FAIL ii_disabled: got %0d expected 0", v);
        end
`endif
    endtask

    task automatic test_freeze();
        logic [CW-1:0] v;
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
        freeze = 1'b1; ap_done[0] = 1'b1;
        tick();
        ap_done[0] = 1'b0;
        rd(0, 0, v);
        vectors++;
        if (v !== 8'd1) begin
            miscompares++;
            $display("FAIL freeze_txn: got %0d expected 1", v);
        end
        rd(0, 7, v);
        vectors++;
        if (v !== 8'd1 || busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL freeze_state: got state=%0d busy=%b expected 1/1", v, busy[0]);
        end
        freeze = 1'b0; ap_done[0] = 1'b1;
        tick();
        ap_done[0] = 1'b0;
        rd(0, 0, v);
        vectors++;
        if (v !== 8'd2) begin
            miscompares++;
            $display("FAIL freeze_resume_txn: got %0d expected 2", v);
        end
        rd(0, 1, v);
        vectors++;
        if (v !== 8'd2) begin
            miscompares++;
            $display("FAIL freeze_resume_lat: got %0d expected 2", v);
        end
    endtask

    task automatic test_rd_range();
        logic [CW-1:0] v;
        rd(1, 2, v);
        vectors++;
        if (v !== 8'd3) begin
            miscompares++;
            $display("FAIL range_valid: got %0d expected 3", v);
        end
        rd(NCH, 2, v);
        vectors++;
        if (v !== 8'd0) begin
            miscompares++;
            $display("FAIL range_numch: got %0d expected 0", v);
        end
        rd(7, 0, v);
        vectors++;
        if (v !== 8'd0) begin
            miscompares++;
            $display("FAIL range_top: got %0d expected 0", v);
        end
    endtask

    task automatic test_clear();
        logic [CW-1:0] v;
        ap_start[1] = 1'b1; ap_ready[1] = 1'b1;
        tick();
        ap_start[1] = 1'b0; ap_ready[1] = 1'b0;
        tick();
        clear = 1'b1; ap_done[1] = 1'b1;
        tick();
        clear = 1'b0; ap_done[1] = 1'b0;
        vectors++;
        if (busy !== 5'd0) begin
            miscompares++;
            $display("FAIL clear_busy: got %b expected 00000", busy);
        end
        rd(1, 0, v);
        vectors++;
        if (v !== 8'd0) begin
            miscompares++;
            $display("FAIL clear_txn: got %0d expected 0", v);
        end
        rd(1, 2, v);
        vectors++;
        if (v !== 8'hFF) begin
            miscompares++;
            $display("FAIL clear_min: got %h expected ff", v);
        end
        rd(3, 0, v);
        vectors++;
        if (v !== 8'd0) begin
            miscompares++;
            $display("FAIL clear_other_txn: got %0d expected 0", v);
        end
        rd(2, 4, v);
        vectors++;
        if (v !== 8'd0) begin
            miscompares++;
            $display("FAIL clear_stall: got %0d expected 0", v);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [CW-1:0] v;
        rd_ch = 3'd0; rd_sel = 3'd2;
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
        tick();
        vectors++;
        if (busy[0] !== 1'b1 || rd_data !== 8'hFF) begin
            miscompares++;
            $display("FAIL pre_reset: got busy=%b rd_data=%h expected 1/ff", busy[0], rd_data);
        end
        reset = 1'b0;
        #2;
        vectors++;
        if (busy !== 5'd0 || rd_data !== 8'd0) begin
            miscompares++;
            $display("FAIL async_reset: got busy=%b rd_data=%h expected 0/0", busy, rd_data);
        end
        #2;
        reset = 1'b1;
        rd(0, 7, v);
        vectors++;
        if (v !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected 0", v);
        end
        rd(0, 2, v);
        vectors++;
        if (v !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_min: got %h expected ff", v);
        end
    endtask

    initial begin
        reset       = 1'b0;
        ap_start    = {NCH{1'b0}};
        ap_ready    = {NCH{1'b0}};
        ap_done     = {NCH{1'b0}};
        ap_continue = {NCH{1'b1}};
        freeze      = 1'b0;
        clear       = 1'b0;
        rd_ch       = 3'd0;
        rd_sel      = 3'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_overlap_sat();
        test_same_cycle();
        test_ii();
        test_freeze();
        test_rd_range();
        test_clear();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
